// File: rtl/platform_rom_arbiter_pkg.sv
// Shared definitions for the platform/wall tile ROM and its requesters.
package platform_rom_arbiter_pkg;

  localparam int unsigned ADDR_W       = 11;  // {row[6:0], col[3:0]}
  localparam int unsigned DATA_W       = 12;  // RGB444
  localparam int unsigned STARVE_LIMIT = 64;
  localparam int unsigned WAIT_W       = 8;

  localparam logic [DATA_W-1:0] TRANSPARENT = 12'h6DE;

  // Owner of the ROM access travelling down the pipeline
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_PIX  = 2'd1,
    TAG_COL  = 2'd2
  } rom_tag_e;

  // Collision request tracking: at most one access outstanding
  typedef enum logic {
    C_IDLE = 1'b0,
    C_WAIT = 1'b1
  } col_state_e;

  // A tile colour counts as solid unless it is the colour key
  function automatic logic is_opaque(input logic [DATA_W-1:0] colour);
    return colour != TRANSPARENT;
  endfunction

endpackage

// File: rtl/platform_rom_arbiter_tag_pipe.sv
// Two-stage tag shift register following each access through ROM latency.
module rom_tag_pipe
  import platform_rom_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_tag,
  output logic [1:0] o_tag_s2
);

  logic [1:0] r_tag_s1;
  logic [1:0] r_tag_s2;

  // Stage 1 aligns with mem_en/mem_addr, stage 2 with mem_data; reset flushes both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_s1 <= 2'(TAG_NONE);
      r_tag_s2 <= 2'(TAG_NONE);
    end else begin
      r_tag_s1 <= i_tag;
      r_tag_s2 <= r_tag_s1;
    end
  end

  assign o_tag_s2 = r_tag_s2;

endmodule

// File: rtl/platform_rom_arbiter.sv
// Fixed-priority arbiter sharing the tile ROM between renderer and collision unit.
module platform_rom_arbiter
  import platform_rom_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_pix_req,
  input  logic [ADDR_W-1:0] i_pix_addr,
  output logic              o_pix_valid,
  output logic [DATA_W-1:0] o_pix_data,
  output logic              o_pix_opaque,
  input  logic              i_col_req,
  input  logic [ADDR_W-1:0] i_col_addr,
  output logic              o_col_gnt,
  output logic              o_col_valid,
  output logic [DATA_W-1:0] o_col_data,
  output logic              o_col_opaque,
  output logic              o_mem_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic              o_starve_err
);

  col_state_e        r_col_state;
  col_state_e        w_col_state_nxt;
  rom_tag_e          w_issue_tag;
  logic              w_col_gnt;
  logic [1:0]        w_tag_s2;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_nxt;

  logic              r_mem_en;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_pix_valid;
  logic [DATA_W-1:0] r_pix_data;
  logic              r_pix_opaque;
  logic              r_col_valid;
  logic [DATA_W-1:0] r_col_data;
  logic              r_col_opaque;
  logic              r_starve_err;

  // Arbitration: render always wins; collision only when nothing of its own is in flight
  always_comb begin
    w_col_gnt   = rst_n & i_col_req & ~i_pix_req & (r_col_state == C_IDLE);
    w_issue_tag = TAG_NONE;
    if (i_pix_req) begin
      w_issue_tag = TAG_PIX;
    end else if (w_col_gnt) begin
      w_issue_tag = TAG_COL;
    end
  end

  // Collision FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_state <= C_IDLE;
    end else begin
      r_col_state <= w_col_state_nxt;
    end
  end

  // Collision FSM next state: busy from grant until its result is delivered
  always_comb begin
    w_col_state_nxt = r_col_state;
    case (r_col_state)
      C_IDLE:  if (w_col_gnt)   w_col_state_nxt = C_WAIT;
      C_WAIT:  if (r_col_valid) w_col_state_nxt = C_IDLE;
      default: w_col_state_nxt = C_IDLE;
    endcase
  end

  // Issue stage: address holds when the ROM is idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_en   <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_mem_en <= (w_issue_tag != TAG_NONE);
      if (i_pix_req) begin
        r_mem_addr <= i_pix_addr;
      end else if (w_col_gnt) begin
        r_mem_addr <= i_col_addr;
      end
    end
  end

  rom_tag_pipe u_tag_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_tag    (w_issue_tag),
    .o_tag_s2 (w_tag_s2)
  );

  // Result capture: steer ROM data to its owner, other owner's data holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_valid  <= 1'b0;
      r_pix_data   <= '0;
      r_pix_opaque <= 1'b0;
      r_col_valid  <= 1'b0;
      r_col_data   <= '0;
      r_col_opaque <= 1'b0;
    end else begin
      r_pix_valid <= (w_tag_s2 == 2'(TAG_PIX));
      r_col_valid <= (w_tag_s2 == 2'(TAG_COL));
      if (w_tag_s2 == 2'(TAG_PIX)) begin
        r_pix_data   <= i_mem_data;
        r_pix_opaque <= is_opaque(i_mem_data);
      end
      if (w_tag_s2 == 2'(TAG_COL)) begin
        r_col_data   <= i_mem_data;
        r_col_opaque <= is_opaque(i_mem_data);
      end
    end
  end

  // Wait counter next value: saturating count of consecutive ungranted request cycles
  always_comb begin
    w_wait_nxt = '0;
    if (i_col_req && !w_col_gnt) begin
      w_wait_nxt = (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + WAIT_W'(1);
    end
  end

  // Wait counter and sticky starvation flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt   <= '0;
      r_starve_err <= 1'b0;
    end else begin
      r_wait_cnt <= w_wait_nxt;
      if (w_wait_nxt >= WAIT_W'(STARVE_LIMIT)) begin
        r_starve_err <= 1'b1;
      end
    end
  end

  assign o_col_gnt    = w_col_gnt;
  assign o_mem_en     = r_mem_en;
  assign o_mem_addr   = r_mem_addr;
  assign o_pix_valid  = r_pix_valid;
  assign o_pix_data   = r_pix_data;
  assign o_pix_opaque = r_pix_opaque;
  assign o_col_valid  = r_col_valid;
  assign o_col_data   = r_col_data;
  assign o_col_opaque = r_col_opaque;
  assign o_starve_err = r_starve_err;

endmodule

// File: tb/tb_platform_rom_arbiter.sv
// Self-checking bench: directed scenarios then random traffic against a cycle-schedule model.
module tb_platform_rom_arbiter;
  import platform_rom_arbiter_pkg::*;

  localparam int NCYC = 3000;

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b0;
  logic              pix_req  = 1'b0;
  logic [ADDR_W-1:0] pix_addr = '0;
  logic              col_req  = 1'b0;
  logic [ADDR_W-1:0] col_addr = '0;
  logic [DATA_W-1:0] mem_data = '0;
  logic              pix_valid, pix_opaque, col_gnt, col_valid, col_opaque;
  logic              mem_en, starve_err;
  logic [DATA_W-1:0] pix_data, col_data;
  logic [ADDR_W-1:0] mem_addr;

  logic [DATA_W-1:0] rom [0:(1<<ADDR_W)-1];

  platform_rom_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_pix_req    (pix_req),
    .i_pix_addr   (pix_addr),
    .o_pix_valid  (pix_valid),
    .o_pix_data   (pix_data),
    .o_pix_opaque (pix_opaque),
    .i_col_req    (col_req),
    .i_col_addr   (col_addr),
    .o_col_gnt    (col_gnt),
    .o_col_valid  (col_valid),
    .o_col_data   (col_data),
    .o_col_opaque (col_opaque),
    .o_mem_en     (mem_en),
    .o_mem_addr   (mem_addr),
    .i_mem_data   (mem_data),
    .o_starve_err (starve_err)
  );

  always #5 clk = ~clk;

  // Synchronous ROM, one cycle read latency
  always @(posedge clk) if (mem_en) mem_data <= rom[mem_addr];

  // Expected-event schedule indexed by cycle
  bit                s_me [NCYC+8];
  logic [ADDR_W-1:0] s_ma [NCYC+8];
  bit                s_pv [NCYC+8];
  logic [DATA_W-1:0] s_pd [NCYC+8];
  bit                s_cv [NCYC+8];
  logic [DATA_W-1:0] s_cd [NCYC+8];

  int t = 0;
  int errors = 0;
  int checks = 0;
  int last_gnt = -100;
  int run = 0;
  bit e_starve = 0;
  logic [DATA_W-1:0] e_pd = '0, e_cd = '0;
  bit e_po = 0, e_co = 0;
  logic [ADDR_W-1:0] e_ma = '0;
  bit col_pend = 0;
  logic [ADDR_W-1:0] col_addr_q = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, t, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare all outputs, advance the model
  task automatic cycle(input bit do_rst, input bit p, input logic [ADDR_W-1:0] pa,
                       input bit c_new, input logic [ADDR_W-1:0] ca, input bit c_cancel);
    bit eg;
    bit busy;
    @(posedge clk);
    #1;
    if (c_cancel) col_pend = 0;
    if (!col_pend && c_new) begin
      col_pend   = 1;
      col_addr_q = ca;
    end
    rst_n    = !do_rst;
    pix_req  = p && !do_rst;
    pix_addr = pa;
    col_req  = col_pend;
    col_addr = col_addr_q;
    #1;
    eg = 0;
    if (do_rst) begin
      for (int k = 0; k < 4; k++) begin
        s_me[t+k] = 0;
        s_pv[t+k] = 0;
        s_cv[t+k] = 0;
      end
      e_pd = '0; e_cd = '0; e_po = 0; e_co = 0; e_ma = '0;
      last_gnt = -100; run = 0; e_starve = 0;
    end else begin
      busy = ((t - last_gnt) >= 1) && ((t - last_gnt) <= 3);
      eg   = col_req && !pix_req && !busy;
      if (s_me[t]) e_ma = s_ma[t];
      if (s_pv[t]) begin e_pd = s_pd[t]; e_po = (s_pd[t] != TRANSPARENT); end
      if (s_cv[t]) begin e_cd = s_cd[t]; e_co = (s_cd[t] != TRANSPARENT); end
    end
    chk("mem_en",     32'(mem_en),     32'(s_me[t]));
    chk("mem_addr",   32'(mem_addr),   32'(e_ma));
    chk("pix_valid",  32'(pix_valid),  32'(s_pv[t]));
    chk("pix_data",   32'(pix_data),   32'(e_pd));
    chk("pix_opaque", 32'(pix_opaque), 32'(e_po));
    chk("col_gnt",    32'(col_gnt),    32'(eg));
    chk("col_valid",  32'(col_valid),  32'(s_cv[t]));
    chk("col_data",   32'(col_data),   32'(e_cd));
    chk("col_opaque", 32'(col_opaque), 32'(e_co));
    chk("starve_err", 32'(starve_err), 32'(e_starve));
    if (!do_rst) begin
      if (pix_req) begin
        s_me[t+1] = 1; s_ma[t+1] = pix_addr;
        s_pv[t+3] = 1; s_pd[t+3] = rom[pix_addr];
      end else if (eg) begin
        s_me[t+1] = 1; s_ma[t+1] = col_addr;
        s_cv[t+3] = 1; s_cd[t+3] = rom[col_addr];
        last_gnt = t;
        col_pend = 0;
      end
      if (col_req && !eg) run++;
      else run = 0;
      if (run >= STARVE_LIMIT) e_starve = 1;
    end
    s_me[t] = 0; s_pv[t] = 0; s_cv[t] = 0;
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, 0, '0, 0);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++)
      rom[i] = ($urandom_range(0, 3) == 0) ? TRANSPARENT : DATA_W'($urandom);
    rom[11'h010] = 12'h6DE;
    rom[11'h123] = 12'hF00;
    rom[11'h055] = 12'h0A5;

    for (int i = 0; i < 3; i++) cycle(1, 0, '0, 0, '0, 0);
    idle(2);
    // Single transparent render read
    cycle(0, 1, 11'h010, 0, '0, 0);
    idle(4);
    // Lone collision lookup
    cycle(0, 0, '0, 1, 11'h123, 0);
    idle(4);
    // Simultaneous requests: render first, collision next cycle
    cycle(0, 1, 11'h055, 1, 11'h123, 0);
    idle(5);
    // Starvation under continuous render traffic
    cycle(0, 1, ADDR_W'($urandom), 1, 11'h123, 0);
    for (int i = 0; i < 69; i++) cycle(0, 1, ADDR_W'($urandom), 0, '0, 0);
    idle(10);
    // Re-request in the result cycle
    cycle(0, 0, '0, 1, 11'h200, 0);
    idle(2);
    cycle(0, 0, '0, 1, 11'h201, 0);
    idle(6);
    // Reset between issue and result, collision held across reset
    cycle(0, 1, 11'h010, 0, '0, 0);
    idle(1);
    cycle(1, 0, '0, 1, 11'h300, 0);
    idle(6);
    // Random traffic with cancels and occasional resets
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom % 400) == 0, $urandom_range(0, 1) == 1, ADDR_W'($urandom),
            ($urandom % 4) == 0, ADDR_W'($urandom), col_pend && (($urandom % 40) == 0));
    end
    idle(6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/platform_rom_arbiter.md
# platform_rom_arbiter

Time-multiplexes the single synchronous platform/wall tile ROM between two requesters. The pixel renderer issues one read per pixel. The collision checker for character physics issues sporadic tile lookups. The block sits between the floors renderer, the physics/collision unit and the tile ROM. It issues at most one ROM access per clock and returns tagged, registered results with an opacity flag, so neither requester decodes the transparent colour.

## Interface
- ADDR_W, 11: ROM address width ({row[6:0], col[3:0]}).
- DATA_W, 12: RGB444 colour width.
- TRANSPARENT, 12'h6DE: colour key treated as "no tile".
- STARVE_LIMIT, 64: collision wait cycles before `starve_err` sets.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pix_req  in  1  render read request; single-cycle, no backpressure.
- pix_addr  in  ADDR_W  render address, sampled with pix_req.
- pix_valid  out  1  render result strobe.
- pix_data  out  DATA_W  render colour.
- pix_opaque  out  1  pix_data != TRANSPARENT.
- col_req  in  1  collision request; held until col_gnt.
- col_addr  in  ADDR_W  collision address; stable while col_req high.
- col_gnt  out  1  one-cycle grant pulse.
- col_valid  out  1  collision result strobe.
- col_data  out  DATA_W  collision colour.
- col_opaque  out  1  col_data != TRANSPARENT.
- mem_en  out  1  ROM read enable.
- mem_addr  out  ADDR_W  ROM address.
- mem_data  in  DATA_W  ROM data, valid one cycle after mem_en/mem_addr.
- starve_err  out  1  sticky: collision waited ≥ STARVE_LIMIT cycles.

## Operation
- Fixed priority: pix_req always wins. If pix_req is high in a cycle, col_gnt is low in that cycle.
- col_gnt is combinational and asserts when all of the following hold:
  - col_req is high,
  - pix_req is low,
  - the collision FSM is in C_IDLE.
- Collision FSM:
  - C_IDLE → C_WAIT on col_gnt.
  - C_WAIT → C_IDLE in the cycle col_valid asserts.
  - At most one collision access is outstanding. Requesters may raise col_req again in the col_valid cycle; it is granted the following cycle at the earliest.
- Issue stage is registered: mem_en, mem_addr and a slot tag (NONE/PIX/COL) load from the winning requester. If there is no winner, mem_en = 0 and tag = NONE; mem_addr holds its previous value.
- Tag pipeline is two stages, tracking the access through ROM latency. At stage 2, mem_data is registered into pix_data or col_data according to the tag. The matching valid and opaque bits are computed from mem_data in the same cycle.
- The non-selected output data register holds its last value. Valid strobes are single-cycle.
- Wait counter: saturating 8-bit.
  - Increments each cycle that col_req is high and col_gnt is low.
  - Clears on col_gnt and when col_req is low.
  - Sets starve_err when it reaches STARVE_LIMIT. starve_err clears only by reset.
- Protocol violation: col_req dropping before grant cancels the request silently; no access is issued.

## Timing
- Request in cycle N → mem_en/mem_addr in N+1 → mem_data in N+2 → valid/data/opaque registered in N+3. Latency is 3 for both requesters.
- Throughput: one access per cycle. Back-to-back pix_req gives back-to-back pix_valid.
- Simultaneous pix_req and col_req: render is issued; collision is granted in the first subsequent cycle with pix_req low.
- Reset values, all 0:
  - mem_en, mem_addr, pix_valid, pix_data, pix_opaque,
  - col_gnt, col_valid, col_data, col_opaque, starve_err.
  - Tags reset to NONE; FSM resets to C_IDLE.
- Reset mid-operation: in-flight accesses are discarded, with no valid strobe after reset release. The FSM returns to C_IDLE, so a requester holding col_req is re-granted normally.

## Structure
- Shared package holds:
  - the tag encoding (NONE = 2'd0, PIX = 2'd1, COL = 2'd2),
  - TRANSPARENT = 12'h6DE,
  - the ADDR_W/DATA_W defaults, reused by the floors renderer and the collision unit.
- Natural sub-module: `rom_tag_pipe`, the two-stage tag shift register with flush on reset. Arbitration, FSM, starvation counter and output registers stay in the top.

## Test plan
- Single pix_req, addr 0x010, ROM returns 0x6DE → pix_valid at N+3, pix_data = 0x6DE, pix_opaque = 0; no col_valid.
- col_req held, addr 0x123, no pix_req, ROM returns 0xF00 → col_gnt in cycle N, col_valid at N+3, col_data = 0xF00, col_opaque = 1; col_gnt low in N+1..N+3.
- pix_req and col_req both high in cycle N:
  - pix_valid at N+3;
  - col_gnt at N+1, col_valid at N+4;
  - mem_addr sequence is pix_addr, then col_addr.
- pix_req high for 70 cycles with col_req held → starve_err rises after 64 wait cycles and stays high after pix_req drops and the collision completes.
- rst_n low for one cycle between an issue and its result → no valid strobes afterward; all outputs are 0 during reset.
- col_req raised again in the col_valid cycle → next col_gnt exactly one cycle later; never two collision accesses outstanding.
